mem_lsu: RTL and testbench

- Memory stage, directly downstream of the EX/MEM pipeline register.
- Consumes the latched write-back triple plus aluop, effective address and store data.
- Runs load/store accesses on a req/ack data bus, stalling the pipeline while an access is outstanding.
- Produces the write-back triple for the MEM/WB register; non-memory ops pass through with zero added latency.

---
 rtl/mem_lsu_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_lsu.sv | 137 +++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory stage: bus widths, memory aluop codes,
// write-back constants and LSU state encodings.
package mem_lsu_pkg;

  localparam int unsigned AluOpBus   = 8;
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam logic              WriteDisable = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;

  function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
  endfunction

  function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend, store replicate/byte enables,
// misalignment detect (MEM_MISALIGN_EXC_EN).
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   rt_data,
  input  logic [RegBus-1:0]   rdata,
  output logic                is_load,
  output logic                is_store,
  output logic [3:0]          be,
  output logic [RegBus-1:0]   wdata,
  output logic [RegBus-1:0]   load_data,
  output logic                misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_load  = is_load_op(aluop);
  assign is_store = is_store_op(aluop);

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword lane uses only addr[1], so a stray addr[0] is masked implicitly.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = '0;
    wdata     = ZeroWord;
    load_data = rdata;
    case (aluop)
      EXE_LB_OP:  begin be = 4'b1111; load_data = {{24{byte_sel[7]}}, byte_sel}; end
      EXE_LBU_OP: begin be = 4'b1111; load_data = {24'h0, byte_sel}; end
      EXE_LH_OP:  begin be = 4'b1111; load_data = {{16{half_sel[15]}}, half_sel}; end
      EXE_LHU_OP: begin be = 4'b1111; load_data = {16'h0, half_sel}; end
      EXE_LW_OP:  be = 4'b1111;
      EXE_SB_OP:  begin be = 4'b0001 << addr_lo; wdata = {4{rt_data[7:0]}}; end
      EXE_SH_OP:  begin be = addr_lo[1] ? 4'b1100 : 4'b0011; wdata = {2{rt_data[15:0]}}; end
      EXE_SW_OP:  begin be = 4'b1111; wdata = rt_data; end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_EXC_EN
  assign misaligned = ((aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) && addr_lo[0]) ||
                      ((aluop inside {EXE_LW_OP, EXE_SW_OP}) && (addr_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: req/ack data bus FSM with timeout, load buffer
// and MEM/WB write-back mux. Optional misalignment trap via MEM_MISALIGN_EXC_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_reg_waddr,
  input  logic                  mem_reg_we,
  input  logic [DATA_W-1:0]     mem_reg_wdata,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [ADDR_W-1:0]     mem_mem_addr,
  input  logic [DATA_W-1:0]     mem_rt_data,
  output logic [RegAddrBus-1:0] wb_reg_waddr,
  output logic                  wb_reg_we,
  output logic [DATA_W-1:0]     wb_reg_wdata,
  output logic                  stallreq_mem,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_W-1:0]     dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [DATA_W-1:0]     dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_W-1:0]     dbus_rdata,
  output logic                  bus_err,
  output logic                  misalign_exc
);

  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  lsu_state_t        state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] load_buf;
  logic              aborted;
  logic              is_load, is_store, is_mem, misaligned;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata, load_data;

  mem_lane_align u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .rt_data    (mem_rt_data),
    .rdata      (load_buf),
    .is_load    (is_load),
    .is_store   (is_store),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign is_mem = is_load | is_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      load_buf     <= '0;
      aborted      <= 1'b0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= '0;
      dbus_wdata   <= '0;
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && misaligned) begin
            aborted      <= 1'b1;
            misalign_exc <= 1'b1;
            state        <= DONE;
          end else if (is_mem) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
            dbus_be    <= lane_be;
            dbus_wdata <= lane_wdata;
            cnt        <= '0;
            aborted    <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (dbus_ack || cnt == TO_LAST) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
            state      <= DONE;
            if (dbus_ack) begin
              load_buf <= dbus_rdata;
            end else begin
              bus_err <= 1'b1;
              aborted <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          aborted <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign stallreq_mem = rst && ((state == IDLE && is_mem) || state == WAIT);

  always_comb begin
    wb_reg_waddr = '0;
    wb_reg_we    = WriteDisable;
    wb_reg_wdata = ZeroWord;
    if (rst) begin
      wb_reg_waddr = mem_reg_waddr;
      wb_reg_wdata = mem_reg_wdata;
      case (state)
        IDLE: wb_reg_we = is_mem ? WriteDisable : mem_reg_we;
        WAIT: wb_reg_we = WriteDisable;
        default: begin
          wb_reg_we = mem_reg_we & is_load & ~aborted;
          if (is_load) wb_reg_wdata = load_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected write-back pushed per op, popped when
// the stall drops; bus fields, stall/req lengths and error pulses checked per op.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_reg_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_reg_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_rt_data;
  logic [4:0]  wb_reg_waddr;
  logic        wb_reg_we;
  logic [31:0] wb_reg_wdata;
  logic        stallreq_mem;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        bus_err;
  logic        misalign_exc;

  mem_lsu #(.ADDR_W(32), .DATA_W(32), .BUS_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_reg_waddr (mem_reg_waddr),
    .mem_reg_we    (mem_reg_we),
    .mem_reg_wdata (mem_reg_wdata),
    .mem_aluop     (mem_aluop),
    .mem_mem_addr  (mem_mem_addr),
    .mem_rt_data   (mem_rt_data),
    .wb_reg_waddr  (wb_reg_waddr),
    .wb_reg_we     (wb_reg_we),
    .wb_reg_wdata  (wb_reg_wdata),
    .stallreq_mem  (stallreq_mem),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .bus_err       (bus_err),
    .misalign_exc  (misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  wa;
    logic        we;
    logic        chk_wd;
    logic [31:0] wd;
  } wb_exp_t;

  wb_exp_t    exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [4:0] wa_seq   = 5'd1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one op at posedge+1, plays the bus slave (ack on WAIT cycle ack_at,
  // 0 = never) and returns at posedge+1 of the cycle after write-back.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata, input int ack_at,
                        input logic [31:0] e_baddr, input logic e_bwe, input logic [3:0] e_be,
                        input logic [31:0] e_bwd, input int e_stall, input int e_req,
                        input int e_berr, input int e_mis, input logic e_wbwe,
                        input logic chk, input logic [31:0] e_wbwd);
    int      stall = 0, req = 0, berr = 0, mis = 0;
    bit      fin = 0;
    wb_exp_t e;
    mem_aluop     = op;
    mem_mem_addr  = addr;
    mem_rt_data   = rt;
    mem_reg_wdata = addr;
    mem_reg_waddr = wa_seq;
    mem_reg_we    = 1'b1;
    dbus_rdata    = rdata;
    exp_q.push_back('{nm, wa_seq, e_wbwe, chk, e_wbwd});
    wa_seq = wa_seq + 5'd1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (bus_err) berr++;
      if (misalign_exc) mis++;
      if (!stallreq_mem) begin
        fin = 1;
        e = exp_q.pop_front();
        check_val({nm, ".wb_we"}, 32'(wb_reg_we), 32'(e.we));
        check_val({nm, ".wb_waddr"}, 32'(wb_reg_waddr), 32'(e.wa));
        if (e.chk_wd) check_val({nm, ".wb_wdata"}, wb_reg_wdata, e.wd);
        check_val({nm, ".req_off"}, 32'(dbus_req), 32'd0);
      end else begin
        stall++;
        if (dbus_req) begin
          req++;
          if (req == 1) begin
            check_val({nm, ".addr"}, dbus_addr, e_baddr);
            check_val({nm, ".bwe"}, 32'(dbus_we), 32'(e_bwe));
            check_val({nm, ".be"}, 32'(dbus_be), 32'(e_be));
            if (e_bwe) check_val({nm, ".bwdata"}, dbus_wdata, e_bwd);
          end
          if (req == ack_at) dbus_ack = 1'b1;
        end else if (stall == 1) begin
          check_val({nm, ".wb_we_stall"}, 32'(wb_reg_we), 32'd0);
        end
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
      end
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL %s.hang: stall still high after %0d cycles, required release", nm, stall);
    end
    check_val({nm, ".stall"}, stall, e_stall);
    check_val({nm, ".req"}, req, e_req);
    check_val({nm, ".bus_err"}, berr, e_berr);
    check_val({nm, ".misalign"}, mis, e_mis);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    dbus_ack      = 1'b0;
    dbus_rdata    = '0;
    mem_aluop     = EXE_ADD_OP;
    mem_mem_addr  = 32'h55;
    mem_reg_wdata = 32'h55;
    mem_reg_waddr = 5'd7;
    mem_reg_we    = 1'b1;
    mem_rt_data   = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst.wb_we", 32'(wb_reg_we), 32'd0);
    check_val("rst.wb_wdata", wb_reg_wdata, 32'd0);
    check_val("rst.req", 32'(dbus_req), 32'd0);
    check_val("rst.be", 32'(dbus_be), 32'd0);
    check_val("rst.bus_err", 32'(bus_err), 32'd0);
    check_val("rst.misalign", 32'(misalign_exc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_op("add", EXE_ADD_OP, 32'h1234, 32'h0, 32'h0, 0,
           32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 0, 0, 1'b1, 1'b1, 32'h1234);
    run_op("lb", EXE_LB_OP, 32'h103, 32'h0, 32'h80FF_FF7F, 2,
           32'h100, 1'b0, 4'hF, 32'h0, 3, 2, 0, 0, 1'b1, 1'b1, 32'hFFFF_FF80);
    run_op("sh", EXE_SH_OP, 32'h202, 32'h0000_ABCD, 32'h0, 1,
           32'h200, 1'b1, 4'hC, 32'hABCD_ABCD, 2, 1, 0, 0, 1'b0, 1'b0, 32'h0);
    run_op("lw_to", EXE_LW_OP, 32'h40, 32'h0, 32'h1234_5678, 0,
           32'h40, 1'b0, 4'hF, 32'h0, 65, 64, 1, 0, 1'b0, 1'b0, 32'h0);
    run_op("lbu", EXE_LBU_OP, 32'h001, 32'h0, 32'h1234_80FF, 3,
           32'h0, 1'b0, 4'hF, 32'h0, 4, 3, 0, 0, 1'b1, 1'b1, 32'h0000_0080);
    run_op("lh", EXE_LH_OP, 32'h002, 32'h0, 32'h8001_7FFF, 1,
           32'h0, 1'b0, 4'hF, 32'h0, 2, 1, 0, 0, 1'b1, 1'b1, 32'hFFFF_8001);
    run_op("lhu", EXE_LHU_OP, 32'h000, 32'h0, 32'h8001_9ABC, 1,
           32'h0, 1'b0, 4'hF, 32'h0, 2, 1, 0, 0, 1'b1, 1'b1, 32'h0000_9ABC);
    run_op("sb", EXE_SB_OP, 32'h107, 32'h1122_3344, 32'h0, 2,
           32'h104, 1'b1, 4'h8, 32'h4444_4444, 3, 2, 0, 0, 1'b0, 1'b0, 32'h0);
    run_op("sw", EXE_SW_OP, 32'h10, 32'hDEAD_BEEF, 32'h0, 1,
           32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 2, 1, 0, 0, 1'b0, 1'b0, 32'h0);
    run_op("lw_edge", EXE_LW_OP, 32'h30, 32'h0, 32'h0BAD_C0DE, 64,
           32'h30, 1'b0, 4'hF, 32'h0, 65, 64, 0, 0, 1'b1, 1'b1, 32'h0BAD_C0DE);
`ifdef MEM_MISALIGN_EXC_EN
    run_op("lw_mis", EXE_LW_OP, 32'h006, 32'h0, 32'hCAFE_F00D, 1,
           32'h0, 1'b0, 4'h0, 32'h0, 1, 0, 0, 1, 1'b0, 1'b0, 32'h0);
    run_op("lh_mis", EXE_LH_OP, 32'h013, 32'h0, 32'h8001_7FFF, 1,
           32'h0, 1'b0, 4'h0, 32'h0, 1, 0, 0, 1, 1'b0, 1'b0, 32'h0);
`else
    run_op("lw_mis", EXE_LW_OP, 32'h006, 32'h0, 32'hCAFE_F00D, 1,
           32'h004, 1'b0, 4'hF, 32'h0, 2, 1, 0, 0, 1'b1, 1'b1, 32'hCAFE_F00D);
    run_op("lh_mis", EXE_LH_OP, 32'h013, 32'h0, 32'h8001_7FFF, 1,
           32'h010, 1'b0, 4'hF, 32'h0, 2, 1, 0, 0, 1'b1, 1'b1, 32'hFFFF_8001);
`endif

    // Reset asserted mid-WAIT, between clock edges.
    mem_aluop    = EXE_LW_OP;
    mem_mem_addr = 32'h80;
    @(posedge clk);
    #1;
    check_val("rstw.req_up", 32'(dbus_req), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rstw.req", 32'(dbus_req), 32'd0);
    check_val("rstw.stall", 32'(stallreq_mem), 32'd0);
    check_val("rstw.wb_we", 32'(wb_reg_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op("lw_fresh", EXE_LW_OP, 32'h84, 32'h0, 32'h7654_3210, 64,
           32'h84, 1'b0, 4'hF, 32'h0, 65, 64, 0, 0, 1'b1, 1'b1, 32'h7654_3210);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
